fifo_rd_drain: RTL and testbench
================================

Name: fifo_rd_drain

Overview:
- Read-side master for the dual-clock FIFO; lives entirely in the FIFO read-clock domain.
- Issues rinc while the FIFO is non-empty and honours the FIFO's fixed read latency.
- Captures rdata into a small local skid buffer and presents it downstream on a valid/ready interface.
- Counts a programmed frame of TOTAL words, then signals done.

Parameters:
- WIDTH, 32, data word width (matches FIFO WIDTH).
- RD_LAT, 2, cycles from rinc asserted at edge N to rdata valid at edge N+RD_LAT.
- BUF_DEPTH, 4, skid buffer entries; must be >= RD_LAT+1 (power of two).
- TOTAL, 256, words per frame.
- TMO_CYC, 1024, starvation timeout in cycles (used only with the optional feature).

Ports:
- clk  in  1  read-side clock (the FIFO rclk).
- rst_n  in  1  reset.
- start  in  1  one-cycle pulse; begins a frame.
- rempty  in  1  FIFO empty flag (combinational from FIFO).
- rinc  out  1  FIFO read request.
- rdata  in  WIDTH  FIFO read data.
- out_valid  out  1  downstream data valid.
- out_data  out  WIDTH  downstream data.
- out_ready  in  1  downstream accept.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse at frame end.
- rd_count  out  $clog2(TOTAL)+1  words delivered downstream this frame.
- tmo_err  out  1  starvation timeout; present only with FIFO_RD_TMO_EN.

Interface (already decided):
- One clock: clk. Reset rst_n is asynchronous, active-low.
- All flops reset on negedge rst_n.

Behaviour:
- Reset values: rinc=0, out_valid=0, out_data=0, busy=0, done=0, rd_count=0, tmo_err=0; state=IDLE; buffer, in-flight pipe and counters cleared.
- States:
  - IDLE -> RUN on start.
  - RUN -> DRAIN when issued==TOTAL.
  - DRAIN -> DONE when in-flight==0, buffer empty and rd_count==TOTAL.
  - DONE -> IDLE unconditionally.
  - start is ignored outside IDLE.
- busy=1 in RUN and DRAIN. done=1 for exactly the single DONE cycle.
- rinc = (state==RUN) && !rempty && (issued<TOTAL) && (occ+inflight < BUF_DEPTH). Combinational from registered state; never asserted when rempty=1.
- In-flight tracking: an RD_LAT-deep valid shift register, bit 0 loaded with rinc.
  - When the tail bit is 1, rdata is written into the buffer on that edge.
  - inflight = popcount of the shift register.
- Buffer: circular, BUF_DEPTH entries, wrap-around read/write pointers, explicit occupancy counter.
  - out_valid = occ!=0; out_data = entry at read pointer (no extra register stage).
  - Pop when out_valid && out_ready; rd_count increments on each pop.
  - Simultaneous push and pop: occ unchanged, both pointers advance.
  - Credit rule guarantees a push never meets a full buffer. An overflow is a design error; assert in simulation.
- Throughput: one word per cycle sustained when !rempty and out_ready=1.
- Latency: first out_valid appears RD_LAT+1 edges after the first rinc.
- Counters:
  - issued and rd_count are $clog2(TOTAL)+1 bits, cleared on start.
  - rd_count holds its value after done until the next start.
- Reset mid-frame: all state discarded immediately; no done pulse. Words already popped from the FIFO are lost; this is accepted.

Optional Feature:
- Macro FIFO_RD_TMO_EN.
- Defined:
  - A counter increments each RUN cycle with rempty=1 and clears on any rinc.
  - On reaching TMO_CYC: tmo_err=1 (sticky until next start or reset), state -> DRAIN with issued forced to TOTAL.
  - Frame ends with done even though fewer than TOTAL words were delivered.
- Undefined: no counter, no tmo_err port; RUN waits indefinitely.

Decomposition:
- Package fifo_rd_pkg:
  - state enum (IDLE, RUN, DRAIN, DONE), 2 bits.
  - localparams for count width and BUF_DEPTH index width.
- One sub-module: rd_skid_buf (circular buffer with occupancy, parameterised WIDTH/BUF_DEPTH).
- Control, latency pipe and counters stay in the top.

Test Plan:
- Back-to-back: FIFO preloaded with 0..255, out_ready=1, start -> 256 consecutive out_data 0..255, one per cycle after RD_LAT+1 lead; done at rd_count=256.
- Downstream stall: out_ready=0 for 20 cycles mid-frame -> rinc stops after the buffer plus in-flight words reach 4; no data lost or duplicated; order preserved.
- Empty FIFO: rempty toggled 1/0 every 3 cycles -> rinc never high while rempty=1; all 256 words delivered in order.
- Simultaneous push/pop: occ=2, push and pop on the same edge -> occ stays 2; pointers wrap correctly past index 3.
- Reset mid-frame at rd_count=100 -> all outputs return to reset values; a new start delivers a full frame.
- FIFO_RD_TMO_EN with TMO_CYC=16: rempty held 1 after 10 words -> tmo_err=1 on cycle 16, done pulse follows, rd_count=10.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// Shared state encoding and sizing helpers for the FIFO read-side drain master.
package fifo_rd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int DEF_TOTAL     = 256;
   localparam int DEF_BUF_DEPTH = 4;
   localparam int DEF_CNT_W     = $clog2(DEF_TOTAL) + 1;
   localparam int DEF_IDX_W     = $clog2(DEF_BUF_DEPTH);

   // Counters must be able to hold TOTAL itself, hence the extra bit.
   function automatic int cnt_width(input int total);
      return $clog2(total) + 1;
   endfunction

   function automatic int idx_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// Circular skid buffer with explicit occupancy; output is the entry at the read pointer.
module rd_skid_buf
   import fifo_rd_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int BUF_DEPTH = DEF_BUF_DEPTH
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          i_push,
   input  logic [WIDTH-1:0]              i_wdata,
   input  logic                          i_pop,
   output logic                          o_valid,
   output logic [WIDTH-1:0]              o_data,
   output logic [idx_width(BUF_DEPTH):0] o_occ
);
   localparam int               IDX_W    = idx_width(BUF_DEPTH);
   localparam logic [IDX_W:0]   OCC_FULL = (IDX_W+1)'(BUF_DEPTH);

   logic [WIDTH-1:0] r_mem [BUF_DEPTH];
   logic [IDX_W-1:0] r_wptr;
   logic [IDX_W-1:0] r_rptr;
   logic [IDX_W:0]   r_occ;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BUF_DEPTH; i++) r_mem[i] <= '0;
         r_wptr <= '0;
         r_rptr <= '0;
         r_occ  <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wptr] <= i_wdata;
            r_wptr        <= r_wptr + IDX_W'(1);
         end
         if (i_pop)
            r_rptr <= r_rptr + IDX_W'(1);
         // Push and pop together leave occupancy unchanged.
         case ({i_push, i_pop})
            2'b10:   r_occ <= r_occ + (IDX_W+1)'(1);
            2'b01:   r_occ <= r_occ - (IDX_W+1)'(1);
            default: r_occ <= r_occ;
         endcase
      end
   end

   assign o_valid = (r_occ != '0);
   assign o_data  = r_mem[r_rptr];
   assign o_occ   = r_occ;

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(i_push && !i_pop && r_occ == OCC_FULL));
   a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(i_pop && r_occ == '0));

endmodule

// File: rtl/fifo_rd_drain.sv
// Read-side drain master: credit-limited rinc, fixed-latency capture into a skid buffer,
// frame counting. Optional starvation timeout enabled by macro FIFO_RD_TMO_EN.
module fifo_rd_drain
   import fifo_rd_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int RD_LAT    = 2,
   parameter int BUF_DEPTH = DEF_BUF_DEPTH,
   parameter int TOTAL     = DEF_TOTAL
`ifdef FIFO_RD_TMO_EN
   ,
   parameter int TMO_CYC   = 1024
`endif
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic                        rempty,
   output logic                        rinc,
   input  logic [WIDTH-1:0]            rdata,
   output logic                        out_valid,
   output logic [WIDTH-1:0]            out_data,
   input  logic                        out_ready,
   output logic                        busy,
   output logic                        done,
   output logic [cnt_width(TOTAL)-1:0] rd_count
`ifdef FIFO_RD_TMO_EN
   ,
   output logic                        tmo_err
`endif
);
   localparam int CNT_W = cnt_width(TOTAL);
   localparam int IDX_W = idx_width(BUF_DEPTH);
   localparam int FIL_W = IDX_W + 2;

   state_t            r_state;
   state_t            w_state_next;
   logic [CNT_W-1:0]  r_issued;
   logic [CNT_W-1:0]  r_rd_count;
   logic [RD_LAT-1:0] r_pipe;
   logic [RD_LAT-1:0] w_pipe_next;
   logic [IDX_W:0]    w_occ;
   logic [IDX_W:0]    w_inflight;
   logic [FIL_W-1:0]  w_fill;
   logic              w_start;
   logic              w_pop;
   logic              w_push;
   logic              w_credit;
   logic              w_cnt_ok;
   logic              w_tmo_hit;

   assign w_start  = (r_state == IDLE) && start;
   assign w_pop    = out_valid && out_ready;
   assign w_push   = r_pipe[RD_LAT-1];
   assign w_fill   = FIL_W'(w_occ) + FIL_W'(w_inflight);
   assign w_credit = (w_fill < FIL_W'(BUF_DEPTH));

   always_comb begin
      w_inflight = '0;
      for (int i = 0; i < RD_LAT; i++)
         w_inflight = w_inflight + {{IDX_W{1'b0}}, r_pipe[i]};
   end

   generate
      if (RD_LAT == 1) begin : g_pipe_one
         assign w_pipe_next = rinc;
      end else begin : g_pipe_many
         assign w_pipe_next = {r_pipe[RD_LAT-2:0], rinc};
      end
   endgenerate

`ifdef FIFO_RD_TMO_EN
   localparam int TMO_W = $clog2(TMO_CYC + 1);

   logic [TMO_W-1:0] r_tmo_cnt;
   logic             r_tmo_err;

   assign w_tmo_hit = (r_state == RUN) && rempty && (r_tmo_cnt == TMO_W'(TMO_CYC - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tmo_cnt <= '0;
         r_tmo_err <= 1'b0;
      end else begin
         if (w_start || rinc)
            r_tmo_cnt <= '0;
         else if ((r_state == RUN) && rempty)
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
         if (w_start)
            r_tmo_err <= 1'b0;
         else if (w_tmo_hit)
            r_tmo_err <= 1'b1;
      end
   end

   assign tmo_err  = r_tmo_err;
   // A starved frame ends short; everything that was issued still gets delivered.
   assign w_cnt_ok = r_tmo_err || (r_rd_count == CNT_W'(TOTAL));
`else
   assign w_tmo_hit = 1'b0;
   assign w_cnt_ok  = (r_rd_count == CNT_W'(TOTAL));
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= IDLE;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (start) w_state_next = RUN;
         RUN:     if (w_tmo_hit || (r_issued == CNT_W'(TOTAL))) w_state_next = DRAIN;
         DRAIN:   if ((w_inflight == '0) && (w_occ == '0) && w_cnt_ok) w_state_next = DONE;
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state == RUN) || (r_state == DRAIN);
      done = (r_state == DONE);
      rinc = (r_state == RUN) && !rempty && (r_issued < CNT_W'(TOTAL)) && w_credit;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_issued   <= '0;
         r_rd_count <= '0;
         r_pipe     <= '0;
      end else begin
         r_pipe <= w_pipe_next;
         if (w_start)
            r_issued <= '0;
         else if (w_tmo_hit)
            r_issued <= CNT_W'(TOTAL);
         else if (rinc)
            r_issued <= r_issued + CNT_W'(1);
         if (w_start)
            r_rd_count <= '0;
         else if (w_pop)
            r_rd_count <= r_rd_count + CNT_W'(1);
      end
   end

   assign rd_count = r_rd_count;

   rd_skid_buf #(
      .WIDTH     (WIDTH),
      .BUF_DEPTH (BUF_DEPTH)
   ) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_wdata (rdata),
      .i_pop   (w_pop),
      .o_valid (out_valid),
      .o_data  (out_data),
      .o_occ   (w_occ)
   );

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Directed bench for fifo_rd_drain: behavioural FIFO with fixed read latency, table-driven
// start-up/stall vectors, then whole-frame sequences with an in-order scoreboard.
`timescale 1ns/1ps
module tb_fifo_rd_drain;
   localparam int WIDTH  = 32;
   localparam int RD_LAT = 2;
   localparam int TOTAL  = 256;
   localparam int CW     = $clog2(TOTAL) + 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic             rempty;
   logic             rinc;
   logic [WIDTH-1:0] rdata;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;
   logic             busy;
   logic             done;
   logic [CW-1:0]    rd_count;
`ifdef FIFO_RD_TMO_EN
   logic             tmo_err;
`endif

   int checks = 0;
   int errors = 0;
   int exp_word = 0;

   always #5 clk = ~clk;

   fifo_rd_drain #(
      .WIDTH     (WIDTH),
      .RD_LAT    (RD_LAT),
      .BUF_DEPTH (4),
      .TOTAL     (TOTAL)
`ifdef FIFO_RD_TMO_EN
      ,
      .TMO_CYC   (16)
`endif
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .rempty    (rempty),
      .rinc      (rinc),
      .rdata     (rdata),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done),
      .rd_count  (rd_count)
`ifdef FIFO_RD_TMO_EN
      ,
      .tmo_err   (tmo_err)
`endif
   );

   // Behavioural FIFO: word read on the rinc edge appears on rdata RD_LAT edges later.
   logic [WIDTH-1:0] mem [0:2047];
   int               wptr = 0;
   int               rptr = 0;
   logic             force_empty = 1'b0;
   logic             fifo_clr = 1'b0;
   logic [WIDTH-1:0] dl [RD_LAT];

   assign rempty = (rptr == wptr) || force_empty;
   assign rdata  = dl[RD_LAT-1];

   always @(posedge clk) begin
      if (fifo_clr)
         rptr <= wptr;
      else if (rinc)
         rptr <= rptr + 1;
      dl[0] <= rinc ? mem[rptr % 2048] : 32'hDEAD_BEEF;
      for (int i = 1; i < RD_LAT; i++) dl[i] <= dl[i-1];
   end

   task automatic load(input int n);
      for (int k = 0; k < n; k++) begin
         mem[wptr % 2048] = WIDTH'(k);
         wptr = wptr + 1;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Per-cycle scoreboard: runs after the inputs of the cycle settle, before the edge.
   task automatic sb();
      if (rempty)
         chk("rinc_while_empty", 32'(rinc), 32'd0);
      if (rst_n && out_valid && out_ready) begin
         chk("data_order", out_data, 32'(exp_word));
         exp_word++;
      end
   endtask

   task automatic cyc(input logic st, input logic rdy, input logic fe);
      @(negedge clk);
      start       = st;
      out_ready   = rdy;
      force_empty = fe;
      #1;
      sb();
   endtask

   task automatic start_frame();
      exp_word = 0;
      cyc(1'b1, 1'b1, 1'b0);
   endtask

   task automatic frame_end(input string name, input int exp_cnt, input int tog,
                            input int budget, output int ncyc);
      bit got;
      got  = 1'b0;
      ncyc = 0;
      while (!got && ncyc < budget) begin
         cyc(1'b0, 1'b1, (tog != 0) ? (((ncyc / tog) % 2) == 1) : 1'b0);
         ncyc++;
         if (done) got = 1'b1;
      end
      chk({name, "_done_seen"}, 32'(got), 32'd1);
      if (got) begin
         chk({name, "_rd_count"}, 32'(rd_count), 32'(exp_cnt));
         chk({name, "_words"}, 32'(exp_word), 32'(exp_cnt));
         chk({name, "_busy_at_done"}, 32'(busy), 32'd0);
         cyc(1'b0, 1'b1, 1'b0);
         chk({name, "_done_one_cycle"}, 32'(done), 32'd0);
         chk({name, "_rd_count_hold"}, 32'(rd_count), 32'(exp_cnt));
      end
      $display("frame %s: words=%0d rd_count=%0d cycles=%0d", name, exp_word, rd_count, ncyc);
   endtask

   typedef struct {
      logic        st;
      logic        rdy;
      logic        e_rinc;
      logic        e_valid;
      logic        e_busy;
      logic        e_done;
      logic [31:0] e_data;
      int          e_cnt;
   } vec_t;

   vec_t vt [12];

   initial begin
      int  n;
      int  ncyc;
      int  rinc_cnt;
      logic [31:0] a;

      // Start-up with a 3-cycle downstream stall; row k is sampled before edge k after start.
      vt[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 0};
      vt[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 0};
      vt[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 0};
      vt[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 0};
      vt[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 0};
      vt[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'd1, 1};
      vt[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd2, 2};
      vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd2, 2};
      vt[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd2, 2};
      vt[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd2, 2};
      vt[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'd3, 3};
      vt[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'd4, 4};

      rst_n     = 1'b0;
      start     = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_rinc", 32'(rinc), 32'd0);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_out_data", out_data, 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_rd_count", 32'(rd_count), 32'd0);
`ifdef FIFO_RD_TMO_EN
      chk("reset_tmo_err", 32'(tmo_err), 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      cyc(1'b0, 1'b1, 1'b0);
      chk("idle_busy", 32'(busy), 32'd0);

      // Frame 1: table-driven start-up and buffer-full stall, then run to completion.
      load(TOTAL);
      exp_word = 0;
      for (int i = 0; i < 12; i++) begin
         cyc(vt[i].st, vt[i].rdy, 1'b0);
         chk($sformatf("vec%0d_rinc", i), 32'(rinc), 32'(vt[i].e_rinc));
         chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vt[i].e_valid));
         chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].e_busy));
         chk($sformatf("vec%0d_done", i), 32'(done), 32'(vt[i].e_done));
         chk($sformatf("vec%0d_data", i), out_data, vt[i].e_data);
         chk($sformatf("vec%0d_rd_count", i), 32'(rd_count), 32'(vt[i].e_cnt));
      end
      frame_end("table", TOTAL, 0, 1000, ncyc);

      // Frame 2: back-to-back, one word per cycle; done lands RD_LAT+1+TOTAL+2 rows after start.
      load(TOTAL);
      start_frame();
      frame_end("b2b", TOTAL, 0, 1000, ncyc);
      chk("b2b_done_row", 32'(ncyc), 32'(RD_LAT + 1 + TOTAL + 2));

      // Frame 3: one-cycle stall forces push+pop at occupancy 2, then a 20-cycle stall.
      load(TOTAL);
      start_frame();
      n = 0;
      while (rd_count != CW'(99) && n < 400) begin
         cyc(1'b0, 1'b1, 1'b0);
         n++;
      end
      chk("pp_reach_99", 32'(rd_count), 32'd99);
      a = 32'd100;
      cyc(1'b0, 1'b0, 1'b0);
      chk("pp_r0_rinc", 32'(rinc), 32'd1);
      chk("pp_r0_data", out_data, a);
      cyc(1'b0, 1'b1, 1'b0);
      chk("pp_r1_rinc", 32'(rinc), 32'd0);
      chk("pp_r1_data", out_data, a);
      cyc(1'b0, 1'b1, 1'b0);
      chk("pp_r2_rinc", 32'(rinc), 32'd1);
      chk("pp_r2_data", out_data, a + 32'd1);
      cyc(1'b0, 1'b1, 1'b0);
      chk("pp_r3_rinc", 32'(rinc), 32'd1);
      chk("pp_r3_data", out_data, a + 32'd2);
      cyc(1'b0, 1'b1, 1'b0);
      chk("pp_r4_rinc", 32'(rinc), 32'd1);
      chk("pp_r4_data", out_data, a + 32'd3);
      n = 0;
      while (rd_count != CW'(149) && n < 400) begin
         cyc(1'b0, 1'b1, 1'b0);
         n++;
      end
      chk("stall_reach_149", 32'(rd_count), 32'd149);
      rinc_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(1'b0, 1'b0, 1'b0);
         if (rinc) rinc_cnt++;
      end
      chk("stall_rinc_count", 32'(rinc_cnt), 32'd1);
      chk("stall_last_rinc", 32'(rinc), 32'd0);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", out_data, 32'd150);
      frame_end("stall", TOTAL, 0, 1000, ncyc);

      // Frame 4: rempty toggles every 3 cycles.
      load(TOTAL);
      start_frame();
      frame_end("empty_toggle", TOTAL, 3, 2000, ncyc);

      // Frame 5: asynchronous reset mid-frame, then a fresh full frame.
      load(TOTAL);
      start_frame();
      n = 0;
      while (rd_count != CW'(100) && n < 400) begin
         cyc(1'b0, 1'b1, 1'b0);
         n++;
      end
      chk("rst_reach_100", 32'(rd_count), 32'd100);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_rinc", 32'(rinc), 32'd0);
      chk("rst_mid_valid", 32'(out_valid), 32'd0);
      chk("rst_mid_data", out_data, 32'd0);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      chk("rst_mid_done", 32'(done), 32'd0);
      chk("rst_mid_rd_count", 32'(rd_count), 32'd0);
      @(negedge clk);
      fifo_clr = 1'b1;
      @(negedge clk);
      fifo_clr = 1'b0;
      rst_n    = 1'b1;
      load(TOTAL);
      start_frame();
      frame_end("after_reset", TOTAL, 0, 1000, ncyc);

`ifdef FIFO_RD_TMO_EN
      // Frame 6: only 10 words available; starvation timeout ends the frame short.
      begin
         int last_rinc_row;
         int tmo_row;
         load(10);
         start_frame();
         last_rinc_row = 0;
         tmo_row       = -1;
         n             = 0;
         while (tmo_row < 0 && n < 200) begin
            cyc(1'b0, 1'b1, 1'b0);
            n++;
            if (rinc) last_rinc_row = n;
            if (tmo_err) tmo_row = n;
         end
         chk("tmo_seen", 32'(tmo_row >= 0), 32'd1);
         chk("tmo_delay", 32'(tmo_row - last_rinc_row), 32'd17);
         frame_end("timeout", 10, 0, 100, ncyc);
         chk("tmo_sticky", 32'(tmo_err), 32'd1);
         load(TOTAL);
         start_frame();
         cyc(1'b0, 1'b1, 1'b0);
         chk("tmo_clear_on_start", 32'(tmo_err), 32'd0);
         frame_end("after_timeout", TOTAL, 0, 1000, ncyc);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
